wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the CPU's single register-file write port between three result producers: the single-cycle execute path (ALU and upper-immediate results such as LUI/AUIPC), the load unit, and the multicycle mul/div unit. Each producer offers a result with a valid/ready handshake. The arbiter grants one producer per cycle in round-robin order and drives a registered write-back to the register file. It also keeps a saturating count of contention cycles for performance analysis.

## Interface
- DATA_W, 32, width of a result word
- REG_W, 5, width of a destination register index
- i_Clk  input  1  clock; all state updates on the rising edge
- i_Rst_n  input  1  asynchronous active-low reset
- i_ReqValid  input  3  per-requester valid; bit 0 = execute, bit 1 = load, bit 2 = mul/div
- i_ReqRd  input  3*REG_W  packed destination indices; requester k occupies bits [k*REG_W +: REG_W]
- i_ReqData  input  3*DATA_W  packed results; requester k occupies bits [k*DATA_W +: DATA_W]
- o_ReqReady  output  3  one-hot or zero; combinational grant for the current cycle
- i_CntClr  input  1  synchronous clear of o_ConflictCnt
- o_WbEn  output  1  registered register-file write enable
- o_WbRd  output  REG_W  registered write index
- o_WbData  output  DATA_W  registered write data
- o_Grant  output  3  registered one-hot of the requester that transferred in the previous cycle
- o_ConflictCnt  output  16  saturating count of cycles with two or more valid requests

## Operation
- **Transfer rule.** A transfer from requester k happens in any cycle where i_ReqValid[k] and o_ReqReady[k] are both 1.
- **Requester obligations.** A requester holds valid, rd and data stable until its transfer. Dropping valid before the transfer is permitted; the arbiter must not depend on it.
- **Round-robin pointer P.** P is 2 bits, with values 0..2; value 3 never occurs. Reset value is 0.
- **Winner selection.** The winner is the first set bit of i_ReqValid, scanning P, P+1, P+2 mod 3. o_ReqReady is the one-hot of the winner, or 0 if there are no valid requests.
- **Pointer update.** After a transfer from k, P <= (k+1) mod 3. With no transfer, P holds.
- **Ready generation.** o_ReqReady is combinational from i_ReqValid and P only; it has no dependence on i_ReqRd or i_ReqData. It is forced to 0 while i_Rst_n is low.
- **Write-back registers on a transfer from k:**
  - o_WbRd <= rd of k
  - o_WbData <= data of k
  - o_Grant <= one-hot(k)
  - o_WbEn <= 1 if rd != 0, else 0. Writes to x0 are consumed but suppressed.
- **Write-back registers with no transfer:** o_WbEn <= 0 and o_Grant <= 0. o_WbRd and o_WbData hold their values.
- **Conflict counter:**
  - Increments by 1 in every cycle where popcount(i_ReqValid) >= 2.
  - Saturates at 0xFFFF and does not wrap.
  - i_CntClr has priority: the counter becomes 0 on the next edge, even in a contention cycle.
- **Reset (asynchronous).** While i_Rst_n is low, the following are all 0: P, o_WbEn, o_WbRd, o_WbData, o_Grant, o_ConflictCnt, o_ReqReady.
- **Reset mid-operation.** Reset asserted between edges clears all outputs immediately. Any result that was offered but not yet transferred is not written. Arbitration resumes from P=0 on the first edge after release.

## Timing
- Grant latency is 0 cycles: o_ReqReady is valid in the same cycle as i_ReqValid.
- Write-back latency is 1 cycle: o_WbEn, o_WbRd and o_WbData appear after the edge that ends the transfer cycle.
- Throughput is one transfer per cycle. Requesters can be granted back-to-back with no bubble.
- A lone valid requester wins every cycle regardless of P.
- A requester that is continuously valid waits at most 2 cycles under full contention.
- o_ConflictCnt updates on the edge at the end of the counted cycle.

## Test plan
- **Reset values.** Hold i_Rst_n=0 with all requests valid → every output 0 and o_ReqReady=000. Release → o_ReqReady=001 in the first cycle.
- **Single execute result.** Only req0 valid, rd=5, data=0x12345000 → o_ReqReady=001 the same cycle. Next cycle: o_WbEn=1, o_WbRd=5, o_WbData=0x12345000, o_Grant=001. The cycle after: o_WbEn=0, o_Grant=000, o_WbRd and o_WbData hold.
- **Full contention.** All three valid continuously from reset:
  - Grants run 001, 010, 100, 001, ...
  - o_ConflictCnt reads 6 after 6 cycles.
  - Pulsing i_CntClr in a contention cycle → the count reads 0 on the next edge.
- **Pointer skip.** After a grant to req0 (P=1), offer only req0 and req2 → req2 wins first, then req0.
- **x0 suppression.** req1 valid with rd=0, data=0xDEADBEEF → o_ReqReady=010. Next cycle: o_WbEn=0, o_Grant=010, o_WbData=0xDEADBEEF.
- **Mid-burst reset and saturation.**
  - Drop i_Rst_n between edges during full contention → all outputs go to 0 immediately, with no write-back. After release, the first grant goes to req0.
  - Separately, run 65,540 contention cycles → o_ConflictCnt stays at 0xFFFF.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - Requester and write-back signal bundle for wb_port_arbiter
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic [2:0]          i_ReqValid;
  logic [3*REG_W-1:0]  i_ReqRd;
  logic [3*DATA_W-1:0] i_ReqData;
  logic [2:0]          o_ReqReady;
  logic                i_CntClr;
  logic                o_WbEn;
  logic [REG_W-1:0]    o_WbRd;
  logic [DATA_W-1:0]   o_WbData;
  logic [2:0]          o_Grant;
  logic [15:0]         o_ConflictCnt;

  // Producer side: offers results and reads back arbitration state
  modport master (
    output i_ReqValid, i_ReqRd, i_ReqData, i_CntClr,
    input  o_ReqReady, o_WbEn, o_WbRd, o_WbData, o_Grant, o_ConflictCnt
  );

  // Arbiter side
  modport slave (
    input  i_ReqValid, i_ReqRd, i_ReqData, i_CntClr,
    output o_ReqReady, o_WbEn, o_WbRd, o_WbData, o_Grant, o_ConflictCnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - Round-robin arbiter for the shared register-file write port
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  wb_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    PTR_EXE = 2'd0,
    PTR_LD  = 2'd1,
    PTR_MD  = 2'd2
  } ptr_t;

  ptr_t              ptr;
  ptr_t              ptr_next;
  logic [2:0]        valid;
  logic [2:0]        grant;
  logic              xfer;
  logic              conflict;
  logic [REG_W-1:0]  sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              wb_en_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [2:0]        grant_q;
  logic [15:0]       cnt_q;

  assign valid    = bus.i_ReqValid;
  assign xfer     = |grant;
  assign conflict = (valid[0] & valid[1]) | (valid[0] & valid[2]) | (valid[1] & valid[2]);

  // Round-robin pointer: the requester that scans first next cycle
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) ptr <= PTR_EXE;
    else          ptr <= ptr_next;
  end

  // Winner scan starting at the pointer; the pointer moves just past the winner
  always_comb begin
    grant    = 3'b000;
    ptr_next = ptr;
    case (ptr)
      PTR_LD: begin
        if      (valid[1]) grant = 3'b010;
        else if (valid[2]) grant = 3'b100;
        else if (valid[0]) grant = 3'b001;
      end
      PTR_MD: begin
        if      (valid[2]) grant = 3'b100;
        else if (valid[0]) grant = 3'b001;
        else if (valid[1]) grant = 3'b010;
      end
      default: begin
        if      (valid[0]) grant = 3'b001;
        else if (valid[1]) grant = 3'b010;
        else if (valid[2]) grant = 3'b100;
      end
    endcase
    // No handshake may complete while reset is held, even between edges
    if (!i_Rst_n) grant = 3'b000;
    case (grant)
      3'b001:  ptr_next = PTR_LD;
      3'b010:  ptr_next = PTR_MD;
      3'b100:  ptr_next = PTR_EXE;
      default: ptr_next = ptr;
    endcase
  end

  // Steer the winner's destination index and result to the write-back stage
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < 3; k++) begin
      if (grant[k]) begin
        sel_rd   = bus.i_ReqRd[k*REG_W +: REG_W];
        sel_data = bus.i_ReqData[k*DATA_W +: DATA_W];
      end
    end
  end

  // Registered write-back; x0 destinations are consumed without a write
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      grant_q   <= 3'b000;
    end else if (xfer) begin
      wb_en_q   <= (sel_rd != '0);
      wb_rd_q   <= sel_rd;
      wb_data_q <= sel_data;
      grant_q   <= grant;
    end else begin
      wb_en_q   <= 1'b0;
      grant_q   <= 3'b000;
    end
  end

  // Saturating contention counter; clear wins over increment
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                          cnt_q <= 16'h0000;
    else if (bus.i_CntClr)                 cnt_q <= 16'h0000;
    else if (conflict && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'h0001;
  end

  assign bus.o_ReqReady    = grant;
  assign bus.o_WbEn        = wb_en_q;
  assign bus.o_WbRd        = wb_rd_q;
  assign bus.o_WbData      = wb_data_q;
  assign bus.o_Grant       = grant_q;
  assign bus.o_ConflictCnt = cnt_q;

endmodule
